// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: multi-channel servo PWM with shared frame counter, clamped targets and per-frame slew
module servo_pwm_multi #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 32,
  parameter int PERIOD    = 1000000,
  parameter int MIN_PULSE = 50000,
  parameter int MAX_PULSE = 100000,
  parameter int SLEW_STEP = 0
) (
  input  logic              clock_clk,
  input  logic              reset_high,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [3:0]        wr_ch,
  input  logic [CNT_W-1:0]  wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_tick,
  output logic [NUM_CH-1:0] at_target
);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] MIN_W  = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] MAX_W  = CNT_W'(MAX_PULSE);
  localparam logic [CNT_W-1:0] CENTER = CNT_W'((MIN_PULSE + MAX_PULSE) / 2);
  localparam logic [CNT_W-1:0] STEP   = CNT_W'(SLEW_STEP);
  logic [CNT_W-1:0]  count_q, count_d, clamped;
  logic [CNT_W-1:0]  target_q [NUM_CH];
  logic [CNT_W-1:0]  target_d [NUM_CH];
  logic [CNT_W-1:0]  active_q [NUM_CH];
  logic [CNT_W-1:0]  active_d [NUM_CH];
  logic [CNT_W-1:0]  diff     [NUM_CH];
  logic [NUM_CH-1:0] en_req_q, en_req_d, en_q, en_d, pwm_q, pwm_d, at_q, at_d;
  logic              tick_q, tick_d, wrap;
  always_comb begin
    wrap     = count_q == LAST;
    count_d  = wrap ? '0 : count_q + CNT_W'(1);
    clamped  = wr_data < MIN_W ? MIN_W : (wr_data > MAX_W ? MAX_W : wr_data);
    tick_d   = count_q == '0;
    en_d     = wrap ? en_req_q : en_q;
    en_req_d = en_req_q;
    pwm_d    = '0;
    at_d     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      diff[i]     = target_q[i] >= active_q[i] ? target_q[i] - active_q[i] : active_q[i] - target_q[i];
      active_d[i] = !wrap ? active_q[i] :
                    (SLEW_STEP == 0 || diff[i] <= STEP) ? target_q[i] :
                    (target_q[i] > active_q[i] ? active_q[i] + STEP : active_q[i] - STEP);
      target_d[i] = (wr_en && !wr_sel && wr_ch == 4'(i)) ? clamped : target_q[i];
      en_req_d[i] = (wr_en && wr_sel && wr_ch == 4'(i)) ? wr_data[0] : en_req_q[i];
      pwm_d[i]    = en_q[i] && count_q < active_q[i];
      at_d[i]     = active_q[i] == target_q[i];
    end
  end
  always_ff @(posedge clock_clk) begin
    if (reset_high) begin
      count_q  <= '0;
      en_req_q <= '0;
      en_q     <= '0;
      pwm_q    <= '0;
      at_q     <= '1;
      tick_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i] <= CENTER;
        active_q[i] <= CENTER;
      end
    end else begin
      count_q  <= count_d;
      en_req_q <= en_req_d;
      en_q     <= en_d;
      pwm_q    <= pwm_d;
      at_q     <= at_d;
      tick_q   <= tick_d;
      target_q <= target_d;
      active_q <= active_d;
    end
  end
  assign pwm_out    = pwm_q;
  assign frame_tick = tick_q;
  assign at_target  = at_q;
endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: directed and randomized check of servo_pwm_multi against a frame-level reference model
module tb_servo_pwm_multi;
  localparam int P = 100, LO = 10, HI = 20, CTR = 15;
  logic        clk = 1'b0, rst = 1'b1, wr_en = 1'b0, wr_sel = 1'b0;
  logic [3:0]  wr_ch = '0;
  logic [31:0] wr_data = '0;
  logic [1:0]  pwm0, pwm1, at0, at1;
  logic        tick0, tick1;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int m_cnt = 0, cyc = 0, last_tick = -1;
  int m_tgt [2][2];
  int m_act [2][2];
  bit m_enr [2][2];
  bit m_en  [2][2];
  int acc   [2][2];
  int last  [2][2];
  int slew  [2] = '{0, 3};
  always #5 clk = ~clk;
  servo_pwm_multi #(.NUM_CH(2), .CNT_W(32), .PERIOD(P), .MIN_PULSE(LO), .MAX_PULSE(HI), .SLEW_STEP(0)) u0 (
    .clock_clk(clk), .reset_high(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_ch(wr_ch), .wr_data(wr_data),
    .pwm_out(pwm0), .frame_tick(tick0), .at_target(at0));
  servo_pwm_multi #(.NUM_CH(2), .CNT_W(32), .PERIOD(P), .MIN_PULSE(LO), .MAX_PULSE(HI), .SLEW_STEP(3)) u1 (
    .clock_clk(clk), .reset_high(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_ch(wr_ch), .wr_data(wr_data),
    .pwm_out(pwm1), .frame_tick(tick1), .at_target(at1));
  function automatic int toward(int a, int t, int s);
    int d = t > a ? t - a : a - t;
    if (s == 0 || d <= s) return t;
    return t > a ? a + s : a - s;
  endfunction
  function automatic int clamp(logic [31:0] v);
    return v < LO ? LO : (v > HI ? HI : int'(v));
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    logic [1:0] e_pwm [2];
    logic [1:0] e_at  [2];
    logic [1:0] g_pwm [2];
    logic [1:0] g_at  [2];
    logic       g_tick [2];
    logic       e_tick;
    e_tick = !rst && m_cnt == 0;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        e_pwm[d][c] = !rst && m_en[d][c] && m_cnt < m_act[d][c];
        e_at[d][c]  = rst || m_act[d][c] == m_tgt[d][c];
      end
    if (rst) begin
      m_cnt = 0;
      last_tick = -1;
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 2; c++) begin
          m_tgt[d][c] = CTR; m_act[d][c] = CTR; m_enr[d][c] = 0; m_en[d][c] = 0;
        end
    end else begin
      if (m_cnt == P - 1)
        for (int d = 0; d < 2; d++)
          for (int c = 0; c < 2; c++) begin
            m_en[d][c]  = m_enr[d][c];
            m_act[d][c] = toward(m_act[d][c], m_tgt[d][c], slew[d]);
          end
      if (wr_en && wr_ch < 2)
        for (int d = 0; d < 2; d++)
          if (wr_sel) m_enr[d][wr_ch] = wr_data[0];
          else m_tgt[d][wr_ch] = clamp(wr_data);
      m_cnt = m_cnt == P - 1 ? 0 : m_cnt + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    g_pwm[0] = pwm0; g_pwm[1] = pwm1; g_at[0] = at0; g_at[1] = at1; g_tick[0] = tick0; g_tick[1] = tick1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("pwm_dut%0d", d), 32'(g_pwm[d]), 32'(e_pwm[d]));
      chk($sformatf("tick_dut%0d", d), 32'(g_tick[d]), 32'(e_tick));
      chk($sformatf("at_dut%0d", d), 32'(g_at[d]), 32'(e_at[d]));
      for (int c = 0; c < 2; c++) begin
        if (g_tick[d]) begin
          last[d][c] = acc[d][c];
          acc[d][c] = 0;
        end
        acc[d][c] += int'(g_pwm[d][c]);
      end
    end
    if (tick0) begin
      if (last_tick >= 0) chk("tick_gap", 32'(cyc - last_tick), 32'(P));
      last_tick = cyc;
    end
  endtask
  task automatic run_to(int x);
    int k = 0;
    do begin
      step();
      k++;
    end while (m_cnt != x && k < 3 * P);
  endtask
  task automatic wr(logic sel, logic [3:0] ch, logic [31:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_ch = ch; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask
  initial begin
    repeat (3) step();
    rst = 1'b0;
    chk("rst_at", 32'(at0), 32'd3);
    chk("rst_pwm", 32'(pwm0), 32'd0);
    run_to(40);
    wr(1, 0, 1);
    run_to(50);
    run_to(50);
    chk("mid_en_partial_ch0", 32'(last[0][0]), 32'd0);
    run_to(2);
    chk("en_hi_ch0", 32'(last[0][0]), 32'd15);
    chk("en_hi_ch1", 32'(last[0][1]), 32'd0);
    wr(0, 0, 5);
    wr(0, 1, 50);
    wr(1, 1, 1);
    run_to(2);
    run_to(2);
    chk("clamp_lo_ch0", 32'(last[0][0]), 32'd10);
    chk("clamp_hi_ch1", 32'(last[0][1]), 32'd20);
    chk("slew_down_ch0", 32'(last[1][0]), 32'd12);
    chk("slew_up_ch1", 32'(last[1][1]), 32'd18);
    run_to(2);
    wr(0, 0, 15);
    run_to(2);
    run_to(2);
    chk("slew_13", 32'(last[1][0]), 32'd13);
    run_to(2);
    chk("slew_15", 32'(last[1][0]), 32'd15);
    chk("slew_at_15", 32'(at1[0]), 32'd1);
    wr(0, 0, 20);
    run_to(2);
    chk("slew_old_15", 32'(last[1][0]), 32'd15);
    chk("slew_at_18", 32'(at1[0]), 32'd0);
    run_to(2);
    chk("slew_18", 32'(last[1][0]), 32'd18);
    chk("slew_at_20", 32'(at1[0]), 32'd1);
    run_to(2);
    chk("slew_20", 32'(last[1][0]), 32'd20);
    chk("jump_20", 32'(last[0][0]), 32'd20);
    run_to(99);
    wr(0, 0, 10);
    run_to(2);
    chk("edge_wr_prev", 32'(last[0][0]), 32'd20);
    run_to(2);
    chk("edge_wr_kept", 32'(last[0][0]), 32'd20);
    run_to(2);
    chk("edge_wr_new", 32'(last[0][0]), 32'd10);
    run_to(5);
    wr(1, 0, 0);
    run_to(2);
    chk("dis_full_pulse", 32'(last[0][0]), 32'd10);
    run_to(2);
    chk("dis_low", 32'(last[0][0]), 32'd0);
    wr(1, 0, 1);
    run_to(2);
    run_to(7);
    chk("pre_rst_high", 32'(pwm0[0]), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_pwm", 32'(pwm0), 32'd0);
    chk("rst_mid_at", 32'(at1), 32'd3);
    run_to(2);
    run_to(2);
    chk("rst_dis_ch0", 32'(last[0][0]), 32'd0);
    chk("rst_dis_ch1", 32'(last[0][1]), 32'd0);
    wr(1, 0, 1);
    run_to(2);
    run_to(2);
    chk("rst_center_u0", 32'(last[0][0]), 32'd15);
    chk("rst_center_u1", 32'(last[1][0]), 32'd15);
    wr(0, 3, 10);
    wr(1, 3, 1);
    wr(0, 2, 20);
    run_to(2);
    run_to(2);
    chk("bad_ch_ch0", 32'(last[0][0]), 32'd15);
    chk("bad_ch_ch1", 32'(last[0][1]), 32'd0);
    chk("bad_ch_at", 32'(at0), 32'd3);
    repeat (2500) begin
      rst     = $urandom_range(0, 599) == 0;
      wr_en   = $urandom_range(0, 7) == 0;
      wr_sel  = $urandom_range(0, 1) == 1;
      wr_ch   = 4'($urandom_range(0, 3));
      wr_data = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 30);
      step();
    end
    rst = 1'b0;
    wr_en = 1'b0;
    repeat (2 * P) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
